// File: rtl/uart_tx_param_if.sv
// Producer-side handshake for uart_tx_param: word plus ready/valid.
// The producer drives tx_data/tx_valid (master); the transmitter answers
// with tx_ready (slave). A word moves when tx_valid && tx_ready at a clk edge.
interface uart_tx_param_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] tx_data;
  logic                 tx_valid;
  logic                 tx_ready;

  modport master (
    output tx_data,
    output tx_valid,
    input  tx_ready
  );

  modport slave (
    input  tx_data,
    input  tx_valid,
    output tx_ready
  );
endinterface

// File: rtl/uart_tx_param.sv
// uart_tx_param: parametrised UART transmitter (5..9 data bits, none/odd/even
// parity, 1 or 2 stop bits, eight selectable baud rates).
// Frame: start(0), data LSB first, optional parity, stop(1) bits, each bit
// lasting DIV = CLK_FREQ_HZ/baud clocks. The word and baud_sel are latched
// at the ready/valid transfer so the producer may change them freely after.
// Optional feature macro: UART_TX_BREAK_EN adds break_req and the
// BREAK/MARK line-break states.
module uart_tx_param #(
  parameter int CLK_FREQ_HZ = 50_000_000,
  parameter int DATA_BITS   = 8,
  parameter int PARITY      = 0,
  parameter int STOP_BITS   = 1
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic [2:0]    baud_sel,
`ifdef UART_TX_BREAK_EN
  input  logic          break_req,
`endif
  uart_tx_param_if.slave bus,
  output logic          tx,
  output logic          tx_busy,
  output logic          tx_done
);

  // Baud rate selected by each baud_sel code.
  function automatic int baud_rate(input int sel);
    case (sel)
      0:       return 9600;
      1:       return 19200;
      2:       return 38400;
      3:       return 57600;
      4:       return 115200;
      5:       return 230400;
      6:       return 460800;
      default: return 921600;
    endcase
  endfunction

  // Reject illegal configurations when the design is elaborated.
  generate
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
      $error("uart_tx_param: DATA_BITS must be in 5..9");
    end
    if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
      $error("uart_tx_param: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
      $error("uart_tx_param: STOP_BITS must be 1 or 2");
    end
    if (CLK_FREQ_HZ / 9600 >= 65536) begin : g_bad_clk_high
      $error("uart_tx_param: CLK_FREQ_HZ/9600 must fit the 16-bit bit timer");
    end
    if (CLK_FREQ_HZ / 921600 < 1) begin : g_bad_clk_low
      $error("uart_tx_param: CLK_FREQ_HZ too low for the fastest baud rate");
    end
  endgenerate

  // One elaboration-time divisor per baud_sel code.
  logic [15:0] div_table [0:7];

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_div
      localparam int DIV_VAL = CLK_FREQ_HZ / baud_rate(gi);
      assign div_table[gi] = 16'(DIV_VAL);
    end
  endgenerate

  localparam logic [3:0] LAST_DATA  = 4'(DATA_BITS - 1);
  localparam logic [3:0] LAST_STOP  = 4'(STOP_BITS - 1);
  localparam bit         HAS_PARITY = (PARITY != 0);
  localparam bit         ODD_PARITY = (PARITY == 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
`ifdef UART_TX_BREAK_EN
    ,
    ST_BREAK,
    ST_MARK
`endif
  } state_t;

  state_t               state_reg, state_next;
  logic [15:0]          cnt_reg,   cnt_next;    // clocks elapsed in current bit
  logic [3:0]           idx_reg,   idx_next;    // data bit index, reused for stop bits
  logic [DATA_BITS-1:0] shift_reg, shift_next;  // remaining data, bit 0 on the line
  logic                 par_reg,   par_next;    // parity bit of the latched word
  logic [2:0]           sel_reg,   sel_next;    // latched baud_sel
  logic                 tx_reg,    tx_next;

  logic [15:0] div_cur;
  logic        bit_end;

  // Divisor of the latched rate; bit_end marks the final clock of a bit.
  assign div_cur = div_table[sel_reg];
  assign bit_end = (cnt_reg == div_cur - 16'd1);

  // State and datapath registers, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
      idx_reg   <= '0;
      shift_reg <= '0;
      par_reg   <= 1'b0;
      sel_reg   <= '0;
      tx_reg    <= 1'b1;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      idx_reg   <= idx_next;
      shift_reg <= shift_next;
      par_reg   <= par_next;
      sel_reg   <= sel_next;
      tx_reg    <= tx_next;
    end
  end

  // Next-state logic; tx_next is the line level for the upcoming bit so the
  // registered tx changes on the same edge as the state.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    idx_next   = idx_reg;
    shift_next = shift_reg;
    par_next   = par_reg;
    sel_next   = sel_reg;
    tx_next    = tx_reg;

    case (state_reg)
      ST_IDLE: begin
        tx_next  = 1'b1;
        cnt_next = '0;
        idx_next = '0;
`ifdef UART_TX_BREAK_EN
        // A break request takes precedence over a pending word.
        if (break_req) begin
          state_next = ST_BREAK;
          tx_next    = 1'b0;
        end else
`endif
        if (bus.tx_valid) begin
          state_next = ST_START;
          tx_next    = 1'b0;
          shift_next = bus.tx_data;
          sel_next   = baud_sel;
          par_next   = ODD_PARITY ? ~(^bus.tx_data) : (^bus.tx_data);
        end
      end

      ST_START: begin
        if (bit_end) begin
          state_next = ST_DATA;
          cnt_next   = '0;
          idx_next   = '0;
          tx_next    = shift_reg[0];
        end else begin
          cnt_next = cnt_reg + 16'd1;
        end
      end

      ST_DATA: begin
        if (bit_end) begin
          cnt_next = '0;
          if (idx_reg == LAST_DATA) begin
            idx_next = '0;
            if (HAS_PARITY) begin
              state_next = ST_PARITY;
              tx_next    = par_reg;
            end else begin
              state_next = ST_STOP;
              tx_next    = 1'b1;
            end
          end else begin
            idx_next   = idx_reg + 4'd1;
            shift_next = shift_reg >> 1;
            tx_next    = shift_reg[1];
          end
        end else begin
          cnt_next = cnt_reg + 16'd1;
        end
      end

      ST_PARITY: begin
        if (bit_end) begin
          state_next = ST_STOP;
          cnt_next   = '0;
          tx_next    = 1'b1;
        end else begin
          cnt_next = cnt_reg + 16'd1;
        end
      end

      ST_STOP: begin
        tx_next = 1'b1;
        if (bit_end) begin
          cnt_next = '0;
          if (idx_reg == LAST_STOP) begin
            state_next = ST_IDLE;
            idx_next   = '0;
          end else begin
            idx_next = idx_reg + 4'd1;
          end
        end else begin
          cnt_next = cnt_reg + 16'd1;
        end
      end

`ifdef UART_TX_BREAK_EN
      ST_BREAK: begin
        tx_next  = 1'b0;
        cnt_next = '0;
        if (!break_req) begin
          state_next = ST_MARK;
          tx_next    = 1'b1;
        end
      end

      // One idle bit time after a break so the receiver can resync.
      ST_MARK: begin
        tx_next = 1'b1;
        if (bit_end) begin
          state_next = ST_IDLE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + 16'd1;
        end
      end
`endif

      default: begin
        state_next = ST_IDLE;
        cnt_next   = '0;
        idx_next   = '0;
        tx_next    = 1'b1;
      end
    endcase
  end

  // Status outputs decoded from registered state.
  assign tx           = tx_reg;
  assign bus.tx_ready = (state_reg == ST_IDLE);
  assign tx_busy      = (state_reg != ST_IDLE);
  assign tx_done      = (state_reg == ST_STOP) && bit_end && (idx_reg == LAST_STOP);

endmodule

// File: tb/tb_uart_tx_param.sv
// Testbench for uart_tx_param: four instances (8N1, 8E1, 8O1, 7N2) on one
// clock, directed frames with hand-computed bit patterns and timings.
// With UART_TX_BREAK_EN defined the line-break sequence is also exercised.
module tb_uart_tx_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rstn;
  logic [2:0] baud0, baud1, baud2, baud3;
  logic       tx0, tx1, tx2, tx3;
  logic       busy0, busy1, busy2, busy3;
  logic       done0, done1, done2, done3;
`ifdef UART_TX_BREAK_EN
  logic       break_req;
`endif

  uart_tx_param_if #(.DATA_BITS(8)) if0 ();
  uart_tx_param_if #(.DATA_BITS(8)) if1 ();
  uart_tx_param_if #(.DATA_BITS(8)) if2 ();
  uart_tx_param_if #(.DATA_BITS(7)) if3 ();

  uart_tx_param u0 (
    .clk(clk), .rstn(rstn), .baud_sel(baud0),
`ifdef UART_TX_BREAK_EN
    .break_req(break_req),
`endif
    .bus(if0), .tx(tx0), .tx_busy(busy0), .tx_done(done0)
  );

  uart_tx_param #(.PARITY(2)) u1 (
    .clk(clk), .rstn(rstn), .baud_sel(baud1),
`ifdef UART_TX_BREAK_EN
    .break_req(1'b0),
`endif
    .bus(if1), .tx(tx1), .tx_busy(busy1), .tx_done(done1)
  );

  uart_tx_param #(.PARITY(1)) u2 (
    .clk(clk), .rstn(rstn), .baud_sel(baud2),
`ifdef UART_TX_BREAK_EN
    .break_req(1'b0),
`endif
    .bus(if2), .tx(tx2), .tx_busy(busy2), .tx_done(done2)
  );

  uart_tx_param #(.DATA_BITS(7), .STOP_BITS(2)) u3 (
    .clk(clk), .rstn(rstn), .baud_sel(baud3),
`ifdef UART_TX_BREAK_EN
    .break_req(1'b0),
`endif
    .bus(if3), .tx(tx3), .tx_busy(busy3), .tx_done(done3)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Hand-computed 50 MHz divisors for each baud_sel code.
  function automatic int div_of(input int bsel);
    case (bsel)
      0:       return 5208;
      1:       return 2604;
      2:       return 1302;
      3:       return 868;
      4:       return 434;
      5:       return 217;
      6:       return 108;
      default: return 54;
    endcase
  endfunction

  function automatic logic get_tx(input int d);
    case (d)
      0:       return tx0;
      1:       return tx1;
      2:       return tx2;
      default: return tx3;
    endcase
  endfunction

  function automatic logic get_busy(input int d);
    case (d)
      0:       return busy0;
      1:       return busy1;
      2:       return busy2;
      default: return busy3;
    endcase
  endfunction

  function automatic logic get_done(input int d);
    case (d)
      0:       return done0;
      1:       return done1;
      2:       return done2;
      default: return done3;
    endcase
  endfunction

  function automatic logic get_ready(input int d);
    case (d)
      0:       return if0.tx_ready;
      1:       return if1.tx_ready;
      2:       return if2.tx_ready;
      default: return if3.tx_ready;
    endcase
  endfunction

  task automatic drive(input int d, input logic [8:0] data, input logic [2:0] bsel, input logic valid);
    case (d)
      0: begin if0.tx_data = data[7:0]; baud0 = bsel; if0.tx_valid = valid; end
      1: begin if1.tx_data = data[7:0]; baud1 = bsel; if1.tx_valid = valid; end
      2: begin if2.tx_data = data[7:0]; baud2 = bsel; if2.tx_valid = valid; end
      default: begin if3.tx_data = data[6:0]; baud3 = bsel; if3.tx_valid = valid; end
    endcase
  endtask

  task automatic set_valid(input int d, input logic valid);
    case (d)
      0:       if0.tx_valid = valid;
      1:       if1.tx_valid = valid;
      2:       if2.tx_valid = valid;
      default: if3.tx_valid = valid;
    endcase
  endtask

  // Transfer one word and check every clock of the resulting frame.
  // par < 0 means no parity bit; otherwise it is the expected parity level.
  // hold keeps tx_valid high and scrambles tx_data/baud_sel during the frame.
  // imm requires the transfer to happen on the very next edge.
  task automatic send_frame(input int d, input logic [8:0] data, input int bsel,
                            input int nbits, input int par, input int stops,
                            input bit hold, input bit imm, input string tag);
    int          div;
    int          nb;
    int          f;
    int          waited;
    int          done_at;
    int          done_cnt;
    int          b;
    logic        busy_ok;
    logic        ready_ok;
    logic        bitv [0:12];
    logic [31:0] obs  [0:12];

    div      = div_of(bsel);
    waited   = 0;
    done_at  = -1;
    done_cnt = 0;
    busy_ok  = 1'b1;
    ready_ok = 1'b1;

    bitv[0] = 1'b0;
    for (int i = 0; i < nbits; i++) bitv[1 + i] = data[i];
    nb = 1 + nbits;
    if (par >= 0) begin
      bitv[nb] = par[0];
      nb++;
    end
    for (int i = 0; i < stops; i++) begin
      bitv[nb] = 1'b1;
      nb++;
    end
    f = nb * div;
    for (int i = 0; i < nb; i++) obs[i] = {31'd0, bitv[i]};

    while (get_ready(d) !== 1'b1 && waited < 60000) begin
      @(posedge clk); #1;
      waited++;
    end
    check({tag, ".ready_in"}, get_ready(d), 1);
    if (imm) check({tag, ".wait_cycles"}, waited, 0);

    drive(d, data, 3'(bsel), 1'b1);
    @(posedge clk); #1;                    // transfer edge k; now in cycle k+1
    if (!hold) set_valid(d, 1'b0);

    for (int cyc = 1; cyc <= f; cyc++) begin
      if (cyc > 1) begin @(posedge clk); #1; end
      b = (cyc - 1) / div;
      if (get_tx(d) !== bitv[b]) obs[b] = {31'd0, get_tx(d)};
      if (get_done(d) === 1'b1) begin done_cnt++; done_at = cyc; end
      if (get_busy(d) !== 1'b1) busy_ok = 1'b0;
      if (get_ready(d) !== 1'b0) ready_ok = 1'b0;
      if (hold && ((cyc - 1) % div) == 0) drive(d, 9'($urandom), 3'($urandom), 1'b1);
    end

    for (int i = 0; i < nb; i++) check($sformatf("%s.bit%0d", tag, i), obs[i], {31'd0, bitv[i]});
    check({tag, ".done_cycle"}, done_at, f);
    check({tag, ".done_count"}, done_cnt, 1);
    check({tag, ".busy_frame"}, busy_ok, 1);
    check({tag, ".ready_frame"}, ready_ok, 1);

    @(posedge clk); #1;                    // cycle k+F+1: back in IDLE
    check({tag, ".ready_after"}, get_ready(d), 1);
    check({tag, ".busy_after"}, get_busy(d), 0);
    check({tag, ".tx_after"}, get_tx(d), 1);
    check({tag, ".done_after"}, get_done(d), 0);
    $display("frame %s: dut %0d data %0h baud_sel %0d F=%0d done_at=%0d", tag, d, data, bsel, f, done_at);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rstn = 1'b0;
`ifdef UART_TX_BREAK_EN
    break_req = 1'b0;
`endif
    for (int d = 0; d < 4; d++) drive(d, 9'd0, 3'd0, 1'b0);

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst.tx0", tx0, 1);
    check("rst.tx3", tx3, 1);
    check("rst.busy0", busy0, 0);
    check("rst.done0", done0, 0);
    rstn = 1'b1;
    @(posedge clk); #1;
    check("rst.ready0", if0.tx_ready, 1);
    check("rst.ready3", if3.tx_ready, 1);
    $display("reset: tx0=%0b busy0=%0b ready0=%0b", tx0, busy0, if0.tx_ready);

    // 8N1 0x55, 8E1/8O1 0x07 at 115200; 7N2 0x41 at 9600, all in parallel.
    fork
      send_frame(0, 9'h055, 4, 8, -1, 1, 1'b0, 1'b0, "t1_8n1");
      begin
        send_frame(1, 9'h007, 4, 8, 1, 1, 1'b0, 1'b0, "t2_even");
        send_frame(2, 9'h007, 4, 8, 0, 1, 1'b0, 1'b0, "t2_odd");
      end
      send_frame(3, 9'h041, 0, 7, -1, 2, 1'b0, 1'b0, "t3_7n2");
    join

    // Inputs changing mid-frame; back-to-back transfer at k+F+1.
    send_frame(0, 9'h0C3, 7, 8, -1, 1, 1'b1, 1'b0, "t4_hold");
    drive(0, 9'h05A, 3'd6, 1'b1);
    send_frame(0, 9'h05A, 6, 8, -1, 1, 1'b0, 1'b1, "t4_next");

    // Reset in the middle of DATA.
    drive(0, 9'h03C, 3'd7, 1'b1);
    @(posedge clk); #1;
    set_valid(0, 1'b0);
    repeat (216) @(posedge clk);
    #1;
    check("t5.busy_mid", busy0, 1);
    rstn = 1'b0;
    @(posedge clk); #1;
    check("t5.tx", tx0, 1);
    check("t5.busy", busy0, 0);
    check("t5.done", done0, 0);
    rstn = 1'b1;
    @(posedge clk); #1;
    check("t5.ready", if0.tx_ready, 1);
    $display("reset mid-frame: tx0=%0b busy0=%0b ready0=%0b", tx0, busy0, if0.tx_ready);
    send_frame(0, 9'h0A5, 7, 8, -1, 1, 1'b0, 1'b0, "t5_clean");

`ifdef UART_TX_BREAK_EN
    // Break with a word pending; latched baud_sel is 7 (DIV=54).
    begin
      logic tx_ok, rdy_ok, done_ok, busy_ok;
      tx_ok = 1'b1; rdy_ok = 1'b1; done_ok = 1'b1; busy_ok = 1'b1;
      drive(0, 9'h0E1, 3'd7, 1'b1);
      break_req = 1'b1;
      for (int i = 1; i <= 10000; i++) begin
        @(posedge clk); #1;
        if (tx0 !== 1'b0) tx_ok = 1'b0;
        if (if0.tx_ready !== 1'b0) rdy_ok = 1'b0;
        if (done0 !== 1'b0) done_ok = 1'b0;
        if (busy0 !== 1'b1) busy_ok = 1'b0;
      end
      check("t6.break_tx", tx_ok, 1);
      check("t6.break_ready", rdy_ok, 1);
      check("t6.break_done", done_ok, 1);
      check("t6.break_busy", busy_ok, 1);
      break_req = 1'b0;
      tx_ok = 1'b1; rdy_ok = 1'b1; done_ok = 1'b1;
      for (int j = 1; j <= 54; j++) begin
        @(posedge clk); #1;
        if (tx0 !== 1'b1) tx_ok = 1'b0;
        if (if0.tx_ready !== 1'b0) rdy_ok = 1'b0;
        if (done0 !== 1'b0) done_ok = 1'b0;
      end
      check("t6.mark_tx", tx_ok, 1);
      check("t6.mark_ready", rdy_ok, 1);
      check("t6.mark_done", done_ok, 1);
      @(posedge clk); #1;
      check("t6.ready_after", if0.tx_ready, 1);
      $display("break: 10000 low cycles, 54 mark cycles, ready0=%0b", if0.tx_ready);
      send_frame(0, 9'h0E1, 7, 8, -1, 1, 1'b0, 1'b1, "t6_word");
    end
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
